// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-pair holding register behind a valid/ready handshake,
// internally generated BCLK/LRCLK, MSB-first serial data with the standard 1-BCLK delay.
module i2s_transmitter #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                in_ready,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDOUT,
    output logic                underrun
);

    localparam int BW = $clog2(2 * SLOT_W);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [SAMPLE_W-1:0] hold_l, hold_r, shift_l, shift_r;
    logic                hold_full;
    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt, bit_nxt;
    logic                accept, start, div_wrap, fall, boundary;
    logic                lr_nxt, sd_nxt;
    int                  b_idx, s_idx;

    assign in_ready = ~hold_full;
    assign accept   = in_valid && !hold_full;

    always_comb begin
        div_wrap = (div_cnt == DW'(BCLK_DIV - 1));
        fall     = (state == RUN) && div_wrap && BCLK;
        bit_nxt  = (bit_cnt == BW'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BW'(1);
        boundary = fall && (bit_nxt == '0);
        start    = (state == IDLE) && enable && hold_full;
    end

    // Serial bit for the slot position the next falling BCLK edge moves to.
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        b_idx  = int'(bit_nxt);
        lr_nxt = (b_idx >= SLOT_W);
        s_idx  = lr_nxt ? b_idx - SLOT_W : b_idx;
        sd_nxt = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (s_idx == SAMPLE_W - i) sd_nxt = lr_nxt ? shift_r[i] : shift_l[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (boundary && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            shift_l   <= '0;
            shift_r   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            BCLK      <= 1'b0;
            LRCLK     <= 1'b0;
            SDOUT     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                hold_l    <= in_left;
                hold_r    <= in_right;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                div_cnt <= '0;
                BCLK    <= 1'b0;
                LRCLK   <= 1'b0;
                SDOUT   <= 1'b0;
                if (start) begin
                    shift_l   <= hold_l;
                    shift_r   <= hold_r;
                    hold_full <= 1'b0;
                    bit_cnt   <= '0;
                end
            end else begin
                div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
                if (div_wrap) BCLK <= ~BCLK;
                if (fall) begin
                    bit_cnt <= bit_nxt;
                    LRCLK   <= lr_nxt;
                    SDOUT   <= sd_nxt;
                end
                // A stop at the boundary needs nothing extra: BCLK/LRCLK/SDOUT are already 0 here.
                if (boundary && enable) begin
                    if (hold_full) begin
                        shift_l   <= hold_l;
                        shift_r   <= hold_r;
                        hold_full <= 1'b0;
                    end else begin
                        shift_l  <= '0;
                        shift_r  <= '0;
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: reset table, frame table with scoreboard,
// back-to-back, underrun, stop/restart, async reset, and a reduced-parameter instance.
module tb_i2s_transmitter;

    localparam int SAMPLE_W = 24;
    localparam int SLOT_W   = 32;
    localparam int BCLK_DIV = 4;
    localparam int FRAME    = 2 * SLOT_W;
    localparam int LIMIT    = 4000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        enable = 1'b0, in_valid = 1'b0;
    logic [23:0] in_left = '0, in_right = '0;
    logic        in_ready, bclk, lrclk, sdout, underrun;

    logic        enable2 = 1'b0, in_valid2 = 1'b0;
    logic [23:0] left2 = '0, right2 = '0;
    logic        in_ready2, bclk2, lrclk2, sdout2, underrun2;

    i2s_transmitter #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
        .BCLK(bclk), .LRCLK(lrclk), .SDOUT(sdout), .underrun(underrun)
    );

    i2s_transmitter #(.SAMPLE_W(24), .SLOT_W(25), .BCLK_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .in_valid(in_valid2),
        .in_left(left2), .in_right(right2), .in_ready(in_ready2),
        .BCLK(bclk2), .LRCLK(lrclk2), .SDOUT(sdout2), .underrun(underrun2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    logic [63:0] sb[$];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling clk edge, assembles 64-bit frames on BCLK rises.
    logic        prev_bclk = 1'b0, prev_sd = 1'b0, prev_ready = 1'b1;
    bit          rise_now = 1'b0;
    int          rise_idx = FRAME - 1;
    int          frames_started = 0, frames_done = 0, rises_total = 0, underruns = 0;
    int          last_rise_cyc = 0;
    int          fstart[$];
    logic [63:0] sd_acc = '0, lr_acc = '0, exp_frame;

    initial forever begin
        @(negedge clk);
        rise_now = 1'b0;
        if (reset) begin
            sb.delete();
            rise_idx = FRAME - 1;
        end else begin
            if (underrun) underruns++;
            if (sdout !== prev_sd) check("sdout_on_fall", {prev_bclk, bclk}, 2'b10);
            if (in_ready && !prev_ready) check("ready_at_boundary", {bclk, lrclk}, 2'b00);
            if (bclk && !prev_bclk) begin
                rise_now = 1'b1;
                rises_total++;
                if (rise_idx == FRAME - 1) begin
                    rise_idx = 0;
                    frames_started++;
                    fstart.push_back(cyc);
                end else begin
                    rise_idx++;
                    check("bclk_period", cyc - last_rise_cyc, 2 * BCLK_DIV);
                end
                last_rise_cyc = cyc;
                sd_acc = {sd_acc[62:0], sdout};
                lr_acc = {lr_acc[62:0], lrclk};
                if (rise_idx == FRAME - 1) begin
                    frames_done++;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_frame");
                    end else begin
                        exp_frame = sb.pop_front();
                        check("frame_sdout", sd_acc, exp_frame);
                        check("frame_lrclk", lr_acc, 64'h00000000_FFFFFFFF);
                    end
                end
            end
        end
        prev_bclk  = bclk;
        prev_sd    = sdout;
        prev_ready = in_ready;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r, input bit drop);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        for (int k = 0; k < LIMIT && !in_ready; k++) tick();
        if (!in_ready) begin
            fail_now("push_timeout");
        end else begin
            tick();
            sb.push_back(frame_of(l, r));
            check("ready_drop", in_ready, 1'b0);
        end
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_started(input int n);
        for (int k = 0; k < LIMIT && frames_started < n; k++) tick();
        if (frames_started < n) fail_now("wait_started");
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < LIMIT && frames_done < n; k++) tick();
        if (frames_done < n) fail_now("wait_done");
    endtask

    task automatic wait_rise(input int frame_no, input int idx);
        bit hit = 1'b0;
        for (int k = 0; k < LIMIT && !hit; k++) begin
            tick();
            hit = rise_now && (rise_idx == idx) && (frames_started == frame_no);
        end
        if (!hit) fail_now("wait_rise");
    endtask

    typedef struct {
        logic        en;
        logic        valid;
        logic [23:0] l;
        logic [23:0] r;
        logic [4:0]  exp_out;   // {in_ready, BCLK, LRCLK, SDOUT, underrun}
    } rst_vec_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] frame;
    } frame_vec_t;

    rst_vec_t    rvec[3];
    frame_vec_t  fvec[3];
    int          base, u0, r0, got, first_cyc, last_cyc;
    logic [49:0] sd2, lr2;
    logic        pb2;

    initial begin
        rvec[0] = '{en: 1'b1, valid: 1'b1, l: 24'h123456, r: 24'hFEDCBA, exp_out: 5'b10000};
        rvec[1] = '{en: 1'b0, valid: 1'b1, l: 24'hFFFFFF, r: 24'h000000, exp_out: 5'b10000};
        rvec[2] = '{en: 1'b1, valid: 1'b0, l: 24'h5A5A5A, r: 24'hA5A5A5, exp_out: 5'b10000};
        fvec[0] = '{l: 24'hA5A5A5, r: 24'h123456, frame: 64'h52D2D280_091A2B00};
        fvec[1] = '{l: 24'hFFFFFF, r: 24'h000001, frame: 64'h7FFFFF80_00000080};
        fvec[2] = '{l: 24'h800000, r: 24'h7FFFFF, frame: 64'h40000000_3FFFFF80};

        // Reset with live inputs.
        for (int i = 0; i < 3; i++) begin
            enable   = rvec[i].en;
            in_valid = rvec[i].valid;
            in_left  = rvec[i].l;
            in_right = rvec[i].r;
            tick();
            check("reset_outputs", {in_ready, bclk, lrclk, sdout, underrun}, rvec[i].exp_out);
        end
        check("reset_outputs_p", {in_ready2, bclk2, lrclk2, sdout2, underrun2}, 5'b10000);
        enable   = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();

        // Single frame then back-to-back, valid held high across pushes.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(fvec[i].l, fvec[i].r, 1'b0);
            if (sb.size() > 0) sb[sb.size() - 1] = fvec[i].frame;
        end
        in_valid = 1'b0;
        wait_started(3);
        enable = 1'b0;
        wait_done(3);
        check("b2b_no_underrun", underruns, 0);
        if (fstart.size() >= 3) begin
            check("b2b_gap_1_2", fstart[1] - fstart[0], FRAME * 2 * BCLK_DIV);
            check("b2b_gap_2_3", fstart[2] - fstart[1], FRAME * 2 * BCLK_DIV);
        end else begin
            fail_now("b2b_frame_starts");
        end

        // Underrun: one pair, a zero frame, then a pair accepted on the underrun edge.
        base = frames_done;
        u0   = underruns;
        enable = 1'b1;
        push(24'h0F0F0F, 24'hF0F0F0, 1'b1);
        sb.push_back(64'h0);
        wait_rise(base + 1, FRAME - 1);
        repeat (BCLK_DIV - 1) tick();
        in_valid = 1'b1;
        in_left  = 24'h3C3C3C;
        in_right = 24'hC3C3C3;
        tick();
        in_valid = 1'b0;
        sb.push_back(frame_of(24'h3C3C3C, 24'hC3C3C3));
        check("underrun_pulse", underrun, 1'b1);
        check("accept_on_underrun_edge", in_ready, 1'b0);
        check("underrun_lrclk", lrclk, 1'b0);
        tick();
        check("underrun_width", underrun, 1'b0);
        wait_started(base + 3);
        enable = 1'b0;
        wait_done(base + 3);
        check("underrun_count", underruns - u0, 1);

        // Stop mid-frame at bit 10, pending pair retained while idle, then restart.
        base = frames_done;
        enable = 1'b1;
        push(24'h111111, 24'h222222, 1'b1);
        wait_started(base + 1);
        push(24'hABCDEF, 24'h654321, 1'b1);
        wait_rise(base + 1, 10);
        enable = 1'b0;
        wait_done(base + 1);
        r0 = rises_total;
        repeat (200) tick();
        check("idle_no_bclk", rises_total, r0);
        check("idle_bclk_low", bclk, 1'b0);
        check("idle_hold_retained", in_ready, 1'b0);
        enable = 1'b1;
        wait_started(base + 2);
        enable = 1'b0;
        wait_done(base + 2);
        check("sb_drained", sb.size(), 0);

        // Asynchronous reset mid-frame with holding full.
        base = frames_done;
        enable = 1'b1;
        push(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        wait_started(base + 1);
        push(24'h777777, 24'h888888, 1'b1);
        wait_rise(base + 1, 20);
        check("pre_reset_bclk", bclk, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset", {in_ready, bclk, lrclk, sdout, underrun}, 5'b10000);
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        r0 = rises_total;
        repeat (50) tick();
        check("post_reset_idle", rises_total, r0);

        // Reduced parameters: BCLK_DIV=1, SLOT_W=25, no padding.
        enable2   = 1'b1;
        in_valid2 = 1'b1;
        left2     = 24'h800001;
        right2    = 24'hC00003;
        for (int k = 0; k < 100 && !in_ready2; k++) tick();
        tick();
        in_valid2 = 1'b0;
        got = 0;
        first_cyc = 0;
        last_cyc = 0;
        sd2 = '0;
        lr2 = '0;
        pb2 = bclk2;
        for (int k = 0; k < 400 && got < 50; k++) begin
            if (bclk2 && !pb2) begin
                sd2 = {sd2[48:0], sdout2};
                lr2 = {lr2[48:0], lrclk2};
                if (got == 0) begin
                    first_cyc = cyc;
                    enable2 = 1'b0;
                end
                last_cyc = cyc;
                got++;
            end
            pb2 = bclk2;
            tick();
        end
        check("p_rises", got, 50);
        check("p_frame_sdout", sd2, {1'b0, 24'h800001, 1'b0, 24'hC00003});
        check("p_frame_lrclk", lr2, 50'h1FFFFFF);
        check("p_bclk_period", last_cyc - first_cyc, 49 * 2);
        check("p_lsb_before_lrclk", {sd2[25], lr2[25], lr2[24]}, 3'b101);
        repeat (120) tick();
        check("p_stopped", {bclk2, lrclk2, sdout2, underrun2}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
